// File: rtl/sw_debounce_pkg.sv
// Shared defaults and sizing helpers for the slide-switch debouncer.
// Imported by the top level and by the per-bit debounce cell.
package sw_debounce_pkg;

  localparam int SW_WIDTH      = 32;
  localparam int SW_TICK_DIV   = 50000;
  localparam int SW_STABLE_CNT = 4;

  // Counter wide enough to hold 0..stable_cnt, never narrower than one bit.
  function automatic int cnt_width(input int stable_cnt);
    int w;
    w = $clog2(stable_cnt + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Prescaler wide enough to hold 0..tick_div-1, never narrower than one bit.
  function automatic int pre_width(input int tick_div);
    int w;
    w = $clog2(tick_div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounced switch bit: accepts a new level after STABLE_CNT consecutive
// differing sample ticks. o_level is registered; o_update flags the accepting edge.
module debounce_cell
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CNT = SW_STABLE_CNT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_level,
  output logic o_level,
  output logic o_update
);

  localparam int            CW       = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          update;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    update  = 1'b0;
    if (i_tick) begin
      // Any tick that sees the accepted level throws away partial progress.
      if (i_level == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = i_level;
        cnt_d   = '0;
        update  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level  = level_q;
  assign o_update = update;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: 2-flop synchronizer, shared sample prescaler,
// per-bit debounce cells, and a registered any-bit-changed pulse.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH      = SW_WIDTH,
  parameter int TICK_DIV   = SW_TICK_DIV,
  parameter int STABLE_CNT = SW_STABLE_CNT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_sw,
  output logic             o_sw_changed
);

  localparam int            PW       = pre_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [WIDTH-1:0] update;
  logic             changed_q, changed_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // With TICK_DIV=1 the prescaler sits at 0 and every cycle is a tick.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    debounce_cell #(
      .STABLE_CNT(STABLE_CNT)
    ) u_cell (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_tick  (tick),
      .i_level (sync2_q[g]),
      .o_level (o_sw[g]),
      .o_update(update[g])
    );
  end

  assign changed_d = |update;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign o_sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=32, TICK_DIV=4, STABLE_CNT=3.
module tb_sw_debounce;

  logic        clk;
  logic        rst;
  logic [31:0] raw;
  logic [31:0] o_sw;
  logic        o_sw_changed;

  int vectors;
  int miscompares;

  sw_debounce #(
    .WIDTH     (32),
    .TICK_DIV  (4),
    .STABLE_CNT(3)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_sw_raw    (raw),
    .o_sw        (o_sw),
    .o_sw_changed(o_sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller has just changed raw or released reset on a negedge; n counts the
  // following negedges, so n = k means o_sw was updated by posedge k.
  task automatic wait_sw(input string tag, input logic [31:0] exp, input int lo, input int hi);
    logic [31:0] start;
    int n, found, pulses, inter;
    logic chg_at;
    start  = o_sw;
    n      = 0;
    found  = -1;
    pulses = 0;
    inter  = 0;
    chg_at = 1'b0;
    while (found < 0 && n < hi + 4) begin
      @(negedge clk);
      n++;
      if (o_sw_changed) pulses++;
      if (o_sw == exp) begin
        found  = n;
        chg_at = o_sw_changed;
      end else if (o_sw != start) begin
        inter++;
      end
    end
    $display("%s: accepted after %0d cycles", tag, found);
    chk({tag, "_in_window"}, 32'(found >= lo && found <= hi), 32'd1);
    chk({tag, "_pulse_aligned"}, {31'd0, chg_at}, 32'd1);
    chk({tag, "_pulse_count"}, pulses, 32'd1);
    chk({tag, "_no_intermediate"}, inter, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse_low"}, {31'd0, o_sw_changed}, 32'd0);
    chk({tag, "_hold"}, o_sw, exp);
  endtask

  task automatic do_reset(input logic [31:0] raw_val);
    @(negedge clk);
    rst = 1'b1;
    raw = raw_val;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses, changes, nonzero;
    logic [31:0] prev;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    raw         = 32'hFFFF_FFFF;

    // Reset held with all switches high; outputs must stay cleared.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_sw", o_sw, 32'd0);
      chk("rst_chg", {31'd0, o_sw_changed}, 32'd0);
    end
    // Release: sync2 valid after edge 2, ticks on edges 4, 8, 12 -> accept at 12.
    rst = 1'b0;
    wait_sw("rst_release", 32'hFFFF_FFFF, 12, 12);

    // Clean step 0 -> A5 from an arbitrary prescaler phase.
    do_reset(32'd0);
    repeat (5) @(negedge clk);
    chk("step_pre", o_sw, 32'd0);
    raw = 32'h0000_00A5;
    wait_sw("step", 32'h0000_00A5, 11, 14);

    // Six-cycle glitch spans at most two ticks and must be rejected.
    do_reset(32'd0);
    repeat (5) @(negedge clk);
    raw = 32'h0000_0008;
    repeat (6) @(negedge clk);
    raw     = 32'd0;
    pulses  = 0;
    nonzero = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_sw_changed) pulses++;
      if (o_sw != 32'd0) nonzero++;
    end
    chk("glitch_sw", nonzero, 32'd0);
    chk("glitch_pulse", pulses, 32'd0);

    // Bit0 bounces every cycle for 20 cycles, then settles high.
    pulses  = 0;
    changes = 0;
    prev    = o_sw;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i < 20) raw[0] = ~raw[0];
      else        raw[0] = 1'b1;
      if (o_sw_changed) pulses++;
      if (o_sw != prev) changes++;
      prev = o_sw;
    end
    chk("bounce_final", o_sw, 32'd1);
    chk("bounce_changes", changes, 32'd1);
    chk("bounce_pulse", pulses, 32'd1);

    // Reset clears o_sw without waiting for a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_sw", o_sw, 32'd0);
    repeat (2) @(negedge clk);
    raw = 32'd1;
    rst = 1'b0;
    // Two ticks of progress (edges 4, 8), then reset before the third.
    repeat (9) @(negedge clk);
    chk("midcnt_pre", o_sw, 32'd0);
    rst = 1'b1;
    #1;
    chk("midcnt_rst_sw", o_sw, 32'd0);
    repeat (3) @(negedge clk);
    chk("midcnt_rst_chg", {31'd0, o_sw_changed}, 32'd0);
    rst = 1'b0;
    wait_sw("midcnt_release", 32'd1, 12, 12);

    // Bit31 rises and bit0 falls on the same tick.
    repeat (3) @(negedge clk);
    raw = 32'h8000_0000;
    wait_sw("simul", 32'h8000_0000, 11, 14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
